// File: rtl/universal_shift_reg.sv
// -----------------------------------------------------------------------------
// universal_shift_reg
//   Multi-function register: parallel load, preset, clear, and multi-bit
//   shifts/rotates executed one bit per clock. Fixed-cost ops and shifts with
//   a zero count finish at the accept edge; an N-bit shift performs its first
//   step at the accept edge and one step on each following edge.
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   start      : request, accepted on a rising edge while busy=0
//   op         : operation code (sampled at accept)
//                000 PRESET, 001 SHL, 010 ROL, 011 SHR,
//                100 ASR, 101 ROR, 110 LOAD, 111 CLEAR
//   amount     : shift count, clamped to WIDTH (sampled at accept)
//   load_data  : parallel value for LOAD (sampled at accept)
//   serial_in  : fill bit for SHL/SHR, sampled on every step edge
//   data_out   : registered register contents
//   serial_out : registered copy of the last bit shifted out
//   busy       : high while a multi-cycle shift is in progress
//   done       : one-cycle completion pulse
// -----------------------------------------------------------------------------
module universal_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [2:0]                         op,
  input  logic [$clog2(WIDTH+1)-1:0]         amount,
  input  logic [WIDTH-1:0]                   load_data,
  input  logic                               serial_in,
  output logic [WIDTH-1:0]                   data_out,
  output logic                               serial_out,
  output logic                               busy,
  output logic                               done
);

  localparam int AMT_W = $clog2(WIDTH+1);

  localparam logic [2:0] OP_PRESET = 3'b000;
  localparam logic [2:0] OP_SHL    = 3'b001;
  localparam logic [2:0] OP_ROL    = 3'b010;
  localparam logic [2:0] OP_SHR    = 3'b011;
  localparam logic [2:0] OP_ASR    = 3'b100;
  localparam logic [2:0] OP_ROR    = 3'b101;
  localparam logic [2:0] OP_LOAD   = 3'b110;
  localparam logic [2:0] OP_CLEAR  = 3'b111;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               sout_q, sout_d;
  logic [AMT_W-1:0]   cnt_q, cnt_d;     // steps still to perform after this one
  logic [2:0]         op_q, op_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [AMT_W-1:0]   amt_clamped_s;
  logic [WIDTH:0]     accept_step_s;
  logic [WIDTH:0]     shift_step_s;

  // One 1-bit step: returns {bit leaving the register, new register value}.
  function automatic logic [WIDTH:0] step_fn(input logic [WIDTH-1:0] d,
                                             input logic [2:0]       o,
                                             input logic             sin);
    case (o)
      OP_SHL:  step_fn = {d[WIDTH-1], d[WIDTH-2:0], sin};
      OP_ROL:  step_fn = {d[WIDTH-1], d[WIDTH-2:0], d[WIDTH-1]};
      OP_SHR:  step_fn = {d[0], sin, d[WIDTH-1:1]};
      OP_ASR:  step_fn = {d[0], d[WIDTH-1], d[WIDTH-1:1]};
      OP_ROR:  step_fn = {d[0], d[0], d[WIDTH-1:1]};
      default: step_fn = {1'b0, d};
    endcase
  endfunction

  assign amt_clamped_s = (amount > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : amount;
  assign accept_step_s = step_fn(data_q, op, serial_in);
  assign shift_step_s  = step_fn(data_q, op_q, serial_in);

  // Next-state logic for the FSM, register contents and status flags.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sout_d  = sout_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          op_d = op;
          case (op)
            OP_PRESET: begin
              data_d = {WIDTH{1'b1}};
              sout_d = 1'b0;
              done_d = 1'b1;
            end
            OP_LOAD: begin
              data_d = load_data;
              sout_d = 1'b0;
              done_d = 1'b1;
            end
            OP_CLEAR: begin
              data_d = {WIDTH{1'b0}};
              sout_d = 1'b0;
              done_d = 1'b1;
            end
            default: begin
              if (amt_clamped_s == {AMT_W{1'b0}}) begin
                // zero-length shift: register and serial_out untouched
                done_d = 1'b1;
              end else begin
                {sout_d, data_d} = accept_step_s;
                if (amt_clamped_s == AMT_W'(1)) begin
                  done_d = 1'b1;
                end else begin
                  state_d = SHIFT;
                  busy_d  = 1'b1;
                  cnt_d   = amt_clamped_s - AMT_W'(1);
                end
              end
            end
          endcase
        end else begin
          cnt_d = {AMT_W{1'b0}};
        end
      end
      SHIFT: begin
        // start is ignored here; the op latched at accept drives every step
        {sout_d, data_d} = shift_step_s;
        if (cnt_q == AMT_W'(1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = {AMT_W{1'b0}};
        end else begin
          busy_d = 1'b1;
          cnt_d  = cnt_q - AMT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        cnt_d   = {AMT_W{1'b0}};
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= {WIDTH{1'b0}};
      sout_q  <= 1'b0;
      cnt_q   <= {AMT_W{1'b0}};
      op_q    <= 3'b000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sout_q  <= sout_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign data_out   = data_q;
  assign serial_out = sout_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_universal_shift_reg
//   Randomized self-checking bench for universal_shift_reg (WIDTH=8).
//   The reference model keeps the register as an integer and applies each
//   operation arithmetically (multiply/divide by two, modulo 256).
// -----------------------------------------------------------------------------
module tb_universal_shift_reg;

  localparam int W     = 8;
  localparam int AMT_W = $clog2(W+1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [2:0]       op = 3'b000;
  logic [AMT_W-1:0] amount = '0;
  logic [W-1:0]     load_data = '0;
  logic             serial_in = 1'b0;
  logic [W-1:0]     data_out;
  logic             serial_out;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_data = 0;
  int m_sout = 0;

  universal_shift_reg #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op         (op),
    .amount     (amount),
    .load_data  (load_data),
    .serial_in  (serial_in),
    .data_out   (data_out),
    .serial_out (serial_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // One model step on the integer register value.
  function automatic void mstep(input int o, input int s);
    int d;
    int msb;
    int lsb;
    d   = m_data;
    msb = d / 128;
    lsb = d % 2;
    case (o)
      1: begin m_sout = msb; d = (d * 2 + s) % 256;   end
      2: begin m_sout = msb; d = (d * 2 + msb) % 256; end
      3: begin m_sout = lsb; d = d / 2 + s * 128;     end
      4: begin m_sout = lsb; d = d / 2 + msb * 128;   end
      5: begin m_sout = lsb; d = d / 2 + lsb * 128;   end
      default: ;
    endcase
    m_data = d;
  endfunction

  // Issue one operation (entered and left just after a falling edge) and check
  // every cycle until the done cycle. sin_mode: 0 random, 1 ones, 2 zeros.
  task automatic run_op(input int o, input int amt, input int ld,
                        input int sin_mode, input bit noise, input string name);
    int n;
    int s;
    bit is_shift;
    is_shift = (o >= 1 && o <= 5);
    n = (amt > W) ? W : amt;
    s = (sin_mode == 1) ? 1 : (sin_mode == 2) ? 0 : int'($urandom_range(1, 0));
    start = 1'b1;
    op = o[2:0];
    amount = amt[AMT_W-1:0];
    load_data = ld[W-1:0];
    serial_in = s[0];
    if (!is_shift) begin
      m_data = (o == 0) ? 255 : (o == 6) ? ld : 0;
      m_sout = 0;
    end else if (n > 0) begin
      mstep(o, s);
    end
    @(posedge clk);
    @(negedge clk);
    // scramble request inputs after accept; they must not matter
    start = 1'b0;
    op = 3'($urandom);
    amount = AMT_W'($urandom);
    load_data = W'($urandom);
    for (int k = 1; k <= ((is_shift && n > 1) ? n : 1); k++) begin
      if (k > 1) begin
        s = (sin_mode == 1) ? 1 : (sin_mode == 2) ? 0 : int'($urandom_range(1, 0));
        serial_in = s[0];
        start = (noise && k == 2) ? 1'b1 : 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        mstep(o, s);
      end
      checks++;
      if (data_out !== m_data[W-1:0]) begin
        errors++;
        $display("FAIL %s data step%0d: got %h expected %h", name, k, data_out, m_data[W-1:0]);
      end
      checks++;
      if (serial_out !== m_sout[0]) begin
        errors++;
        $display("FAIL %s serial_out step%0d: got %b expected %b", name, k, serial_out, m_sout[0]);
      end
      checks++;
      if (busy !== (is_shift && k < n)) begin
        errors++;
        $display("FAIL %s busy step%0d: got %b expected %b", name, k, busy, (is_shift && k < n));
      end
      checks++;
      if (done !== (!is_shift || k >= n)) begin
        errors++;
        $display("FAIL %s done step%0d: got %b expected %b", name, k, done, (!is_shift || k >= n));
      end
    end
  endtask

  // One quiet cycle after a done cycle: pulse ends, register holds.
  task automatic test_idle_gap(input string name);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: done=%b busy=%b expected 0 0", name, done, busy);
    end
    checks++;
    if (data_out !== m_data[W-1:0] || serial_out !== m_sout[0]) begin
      errors++;
      $display("FAIL %s hold: got %h/%b expected %h/%b", name, data_out, serial_out,
               m_data[W-1:0], m_sout[0]);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (data_out !== 8'h00 || serial_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset: got %h %b %b %b expected 00 0 0 0", data_out, serial_out, busy, done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_data = 0;
    m_sout = 0;
  endtask

  task automatic test_rol();
    run_op(6, 0, 8'hA5, 0, 1'b0, "load_a5");
    run_op(2, 3, 0, 0, 1'b0, "rol3");
    checks++;
    if (data_out !== 8'h2D || serial_out !== 1'b1) begin
      errors++;
      $display("FAIL rol3 final: got %h/%b expected 2d/1", data_out, serial_out);
    end
    test_idle_gap("rol3");
  endtask

  task automatic test_clamp();
    run_op(7, 0, 0, 0, 1'b0, "clear");
    run_op(1, 12, 0, 1, 1'b0, "shl12");
    checks++;
    if (data_out !== 8'hFF) begin
      errors++;
      $display("FAIL shl12 final: got %h expected ff", data_out);
    end
    test_idle_gap("shl12");
  endtask

  task automatic test_asr();
    run_op(6, 0, 8'h80, 0, 1'b0, "load_80");
    run_op(4, 2, 0, 0, 1'b0, "asr2");
    checks++;
    if (data_out !== 8'hE0 || serial_out !== 1'b0) begin
      errors++;
      $display("FAIL asr2 final: got %h/%b expected e0/0", data_out, serial_out);
    end
    test_idle_gap("asr2");
  endtask

  task automatic test_back_to_back();
    run_op(6, 0, 8'h5A, 0, 1'b0, "b2b_load");
    run_op(5, 4, 0, 0, 1'b1, "b2b_ror");
    run_op(3, 3, 0, 0, 1'b1, "b2b_shr");
    run_op(2, 1, 0, 0, 1'b0, "b2b_rol1");
    test_idle_gap("b2b");
  endtask

  task automatic test_zero_and_preset();
    run_op(6, 0, 8'h96, 0, 1'b0, "load_96");
    run_op(1, 1, 0, 1, 1'b0, "shl1");
    run_op(3, 0, 0, 0, 1'b0, "shr0");
    checks++;
    if (data_out !== 8'h2D || serial_out !== 1'b1) begin
      errors++;
      $display("FAIL shr0 final: got %h/%b expected 2d/1", data_out, serial_out);
    end
    run_op(0, 5, 0, 0, 1'b0, "preset");
    checks++;
    if (data_out !== 8'hFF || serial_out !== 1'b0) begin
      errors++;
      $display("FAIL preset final: got %h/%b expected ff/0", data_out, serial_out);
    end
    test_idle_gap("preset");
  endtask

  task automatic test_reset_abort();
    bit saw_done;
    run_op(6, 0, 8'hC3, 0, 1'b0, "pre_abort");
    start = 1'b1;
    op = 3'b011;
    amount = AMT_W'(6);
    serial_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL abort busy before reset: got %b expected 1", busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (data_out !== 8'h00 || serial_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort async: got %h %b %b %b expected 00 0 0 0", data_out, serial_out, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_data = 0;
    m_sout = 0;
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || data_out !== 8'h00) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL abort quiet after release: activity seen, expected none");
    end
    run_op(6, 0, 8'h3C, 0, 1'b0, "load_3c");
    checks++;
    if (data_out !== 8'h3C) begin
      errors++;
      $display("FAIL load_3c final: got %h expected 3c", data_out);
    end
    test_idle_gap("load_3c");
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      run_op(int'($urandom_range(7, 0)), int'($urandom_range(15, 0)),
             int'($urandom_range(255, 0)), 0, bit'($urandom), "rand");
      if ($urandom_range(1, 0) == 0) test_idle_gap("rand");
    end
  endtask

  initial begin
    test_reset();
    test_rol();
    test_clamp();
    test_asr();
    test_back_to_back();
    test_zero_and_preset();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8: register width in bits, legal range 2..64.
REQ-002 SHALL derive local parameter AMT_W = $clog2(WIDTH+1): shift-amount width.
REQ-003 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  request; accepted on a rising edge when busy=0.
REQ-006 SHALL have port op  input  3  operation code, sampled at accept.
REQ-007 SHALL have port amount  input  AMT_W  shift count, sampled at accept.
REQ-008 SHALL have port load_data  input  WIDTH  parallel load value, sampled at accept.
REQ-009 SHALL have port serial_in  input  1  fill bit, sampled on every shift edge.
REQ-010 SHALL have port data_out  output  WIDTH  registered register contents.
REQ-011 SHALL have port serial_out  output  1  registered copy of the last bit shifted out.
REQ-012 SHALL have port busy  output  1  high while a multi-cycle shift is in progress.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-014 SHALL use these op codes: 000 PRESET (all ones), 001 SHL (serial_in enters the LSB), 010 ROL, 011 SHR (serial_in enters the MSB), 100 ASR (MSB replicated), 101 ROR, 110 LOAD, 111 CLEAR.
REQ-015 SHALL operate on the internal register; load_data is used only by LOAD.
REQ-016 SHALL implement a two-state FSM with states IDLE and SHIFT.
REQ-017 In IDLE, start=1 SHALL be accepted at the edge.
- PRESET/LOAD/CLEAR and any shift with amount=0: the register update completes at the accept edge.
- done=1 the following cycle.
- The FSM stays in IDLE.
REQ-018 Amount values greater than WIDTH SHALL be clamped to WIDTH.
REQ-019 A shift op with N>=1 SHALL perform one 1-bit step at the accept edge and at each following edge, N steps in total.
- serial_in is sampled on each step edge.
REQ-020 After step N, busy SHALL be 0 and done SHALL be 1 for exactly one cycle.
- For N>=2, busy=1 from after the accept edge through the edge of step N.
REQ-021 serial_out SHALL update on each shift step to the bit leaving the register: MSB for SHL/ROL, LSB for SHR/ASR/ROR.
- PRESET, LOAD and CLEAR SHALL set serial_out to 0.
- serial_out holds its value otherwise.
REQ-022 start while busy=1 SHALL be ignored, with no effect on the op, amount or data.
REQ-023 start in a cycle where done=1 and busy=0 SHALL be accepted (back-to-back operation).
REQ-024 Any op code change during SHIFT SHALL be ignored; the op latched at accept is used.
REQ-025 SHALL produce no X or Z on any output after reset, regardless of serial_in.

Reset
REQ-026 rst_n=0 SHALL immediately, without waiting for clk, force data_out=0, serial_out=0, busy=0, done=0, FSM=IDLE and the step counter to 0.
REQ-027 Reset asserted mid-SHIFT SHALL abort the operation, with no done pulse after release.
REQ-028 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Verification (WIDTH=8)
REQ-029 LOAD 0xA5, then ROL amount=3 -> data_out=0x2D after the third edge; serial_out sequence 1,0,1; busy high for 2 cycles; done pulses once.
REQ-030 From CLEAR, SHL amount=12 with serial_in=1 -> clamped to 8 steps; data_out=0xFF; done after the 8th step edge.
REQ-031 LOAD 0x80, then ASR amount=2 -> data_out=0xE0; serial_out 0,0.
REQ-032 start pulsed mid-shift -> ignored; a new start issued during the done cycle -> accepted; no gap cycle.
REQ-033 Shift with amount=0 -> data_out unchanged and done after 1 cycle; PRESET -> data_out=0xFF and serial_out=0.
REQ-034 rst_n pulsed low during a SHR of amount 6 -> outputs immediately 0, no done pulse; the next LOAD 0x3C succeeds.
